// File: rtl/run_seq_pkg.sv
`default_nettype none
//==============================================================================
// run_seq_pkg : shared state encoding and memory-owner codes for run_sequencer
// Revision    : 1.0
//==============================================================================
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic OWNER_HOST = 1'b0;
    localparam logic OWNER_CORE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/run_sequencer_if.sv
`default_nettype none
//==============================================================================
// run_sequencer_if : run-control, host-arbitration and status signals
// Revision         : 1.0
//==============================================================================
interface run_sequencer_if #(
    parameter int D  = 10,
    parameter int CW = 16
);
    logic          start;
    logic [D-1:0]  start_addr;
    logic          abort;
    logic          core_done;
    logic          host_req;
    logic          host_gnt;
    logic          mem_owner;
    logic          core_rst;
    logic          pc_load;
    logic [D-1:0]  pc_load_val;
    logic          busy;
    logic          ack;
    logic [CW-1:0] cycles;
    logic          timeout;

    // master issues run requests and observes status; slave is the sequencer
    modport master (
        output start, start_addr, abort, core_done, host_req,
        input  host_gnt, mem_owner, core_rst, pc_load, pc_load_val,
               busy, ack, cycles, timeout
    );

    modport slave (
        input  start, start_addr, abort, core_done, host_req,
        output host_gnt, mem_owner, core_rst, pc_load, pc_load_val,
               busy, ack, cycles, timeout
    );

endinterface
`default_nettype wire

// File: rtl/run_cycle_ctr.sv
`default_nettype none
//==============================================================================
// run_cycle_ctr : saturating cycle counter with clear, enable and terminal count
// Revision      : 1.0
//==============================================================================
module run_cycle_ctr #(
    parameter int            CW = 16,
    parameter logic [CW-1:0] TC = '1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_clr,
    input  wire logic          i_en,
    output logic [CW-1:0]      o_count,
    output logic               o_tc
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = (count_q == TC);

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
//==============================================================================
// run_sequencer : holds the core in reset, loads its entry PC, times the run
//                 and arbitrates data-memory ownership with the host port
// Revision      : 1.0
//==============================================================================
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int          D           = 10,
    parameter int          CW          = 16,
    parameter int          RST_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
    input  wire logic      clk,
    input  wire logic      reset,
    run_sequencer_if.slave bus
);

    localparam int            RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

    state_e        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic          core_rst_q, core_rst_d;
    logic          mem_owner_q, mem_owner_d;
    logic          host_gnt_q, host_gnt_d;
    logic          pc_load_q, pc_load_d;
    logic [D-1:0]  pc_load_val_q, pc_load_val_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          timeout_q, timeout_d;

    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          w_cnt_tc;
    logic [CW-1:0] w_cycles;

    run_cycle_ctr #(
        .CW (CW),
        .TC (CW'(TIMEOUT_CYC))
    ) u_cycle_ctr (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cycles),
        .o_tc    (w_cnt_tc)
    );

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        core_rst_d    = core_rst_q;
        mem_owner_d   = mem_owner_q;
        host_gnt_d    = 1'b0;
        pc_load_d     = 1'b0;
        pc_load_val_d = pc_load_val_q;
        busy_d        = busy_q;
        ack_d         = 1'b0;
        timeout_d     = timeout_q;
        w_cnt_clr     = 1'b0;
        w_cnt_en      = 1'b0;

        case (state_q)
            IDLE: begin
                core_rst_d  = 1'b1;
                mem_owner_d = OWNER_HOST;
                busy_d      = 1'b0;
                // an outstanding grant locks out start; otherwise start beats host_req
                if (!host_gnt_q && bus.start) begin
                    state_d       = RESET;
                    rst_cnt_d     = '0;
                    pc_load_val_d = bus.start_addr;
                    timeout_d     = 1'b0;
                    busy_d        = 1'b1;
                    w_cnt_clr     = 1'b1;
                end else begin
                    host_gnt_d = bus.host_req;
                end
            end
            RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d     = LOAD;
                    core_rst_d  = 1'b0;
                    mem_owner_d = OWNER_CORE;
                    pc_load_d   = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.core_done || w_cnt_tc) begin
                    state_d     = DONE;
                    ack_d       = 1'b1;
                    core_rst_d  = 1'b1;
                    mem_owner_d = OWNER_HOST;
                    timeout_d   = !bus.core_done;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort overrides any RESET/LOAD/RUN transition and freezes the count
        if (bus.abort && (state_q == RESET || state_q == LOAD || state_q == RUN)) begin
            state_d     = IDLE;
            core_rst_d  = 1'b1;
            mem_owner_d = OWNER_HOST;
            pc_load_d   = 1'b0;
            busy_d      = 1'b0;
            ack_d       = 1'b0;
            timeout_d   = 1'b0;
            w_cnt_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            core_rst_q    <= 1'b1;
            mem_owner_q   <= OWNER_HOST;
            host_gnt_q    <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            busy_q        <= 1'b0;
            ack_q         <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            core_rst_q    <= core_rst_d;
            mem_owner_q   <= mem_owner_d;
            host_gnt_q    <= host_gnt_d;
            pc_load_q     <= pc_load_d;
            pc_load_val_q <= pc_load_val_d;
            busy_q        <= busy_d;
            ack_q         <= ack_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.core_rst    = core_rst_q;
    assign bus.mem_owner   = mem_owner_q;
    assign bus.host_gnt    = host_gnt_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_load_val = pc_load_val_q;
    assign bus.busy        = busy_q;
    assign bus.ack         = ack_q;
    assign bus.cycles      = w_cycles;
    assign bus.timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
//==============================================================================
// tb_run_sequencer : randomized scoreboard bench for run_sequencer
// Revision         : 1.0
//==============================================================================
module tb_run_sequencer;

    localparam int D       = 10;
    localparam int CW      = 16;
    localparam int RST_CYC = 2;
    localparam int TMO     = 100;

    typedef struct {
        int cyc;
        int tmo;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   prev_ack = 1'b0;

    exp_t           exp_q[$];
    logic [D-1:0]   addr_q[$];

    run_sequencer_if #(.D(D), .CW(CW)) bus ();

    run_sequencer #(
        .D           (D),
        .CW          (CW),
        .RST_CYC     (RST_CYC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ack) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_cycles", bus.cycles, e.cyc);
                    check("ack_timeout", bus.timeout, e.tmo);
                    check("ack_busy", bus.busy, 1);
                    check("ack_core_rst", bus.core_rst, 1);
                    check("ack_mem_owner", bus.mem_owner, 0);
                end
            end
            if (prev_ack) begin
                check("busy_fall_after_ack", bus.busy, 0);
                check("ack_single_pulse", bus.ack, 0);
            end
            if (bus.pc_load) begin
                if (addr_q.size() == 0) begin
                    check("pc_load_unexpected", 32'd1, 32'd0);
                end else begin
                    check("pc_load_val", bus.pc_load_val, addr_q.pop_front());
                    check("load_core_rst", bus.core_rst, 0);
                    check("load_mem_owner", bus.mem_owner, 1);
                end
            end
            if (bus.busy) check("gnt_while_busy", bus.host_gnt, 0);
            prev_ack = bus.ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n: RUN cycles with core_done low before done rises; abort_at >= 0 aborts at that RUN cycle
    task automatic do_run(input logic [D-1:0] addr, input int n, input int abort_at);
        int   k;
        exp_t e;
        bus.start_addr = addr;
        bus.start      = 1'b1;
        addr_q.push_back(addr);
        if (abort_at < 0) begin
            e.cyc = (n <= TMO) ? n : TMO;
            e.tmo = (n > TMO) ? 1 : 0;
            exp_q.push_back(e);
        end
        step();
        bus.start = 1'b0;
        check("accept_busy", bus.busy, 1);
        check("accept_cycles_clr", bus.cycles, 0);
        check("accept_timeout_clr", bus.timeout, 0);
        k = 0;
        while (!bus.pc_load && k < 20) begin
            check("reset_core_rst", bus.core_rst, 1);
            step();
            k++;
        end
        check("reset_length", k, RST_CYC);
        if (!bus.pc_load) return;
        step();
        if (abort_at >= 0) begin
            repeat (abort_at) step();
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            check("abort_busy", bus.busy, 0);
            check("abort_core_rst", bus.core_rst, 1);
            check("abort_cycles", bus.cycles, abort_at);
            check("abort_timeout", bus.timeout, 0);
            check("abort_ack", bus.ack, 0);
            step();
            check("abort_no_ack", bus.ack, 0);
        end else begin
            repeat (n) step();
            bus.core_done = 1'b1;
            k = 0;
            while (bus.busy && k < 300) begin
                step();
                k++;
            end
            check("run_end_busy", bus.busy, 0);
            bus.core_done = 1'b0;
            check("idle_core_rst", bus.core_rst, 1);
            check("idle_mem_owner", bus.mem_owner, 0);
            check("idle_cycles_hold", bus.cycles, e.cyc);
            check("idle_timeout_hold", bus.timeout, e.tmo);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.abort      = 1'b0;
        bus.core_done  = 1'b0;
        bus.host_req   = 1'b0;
        #2;
        check("rst_core_rst", bus.core_rst, 1);
        check("rst_mem_owner", bus.mem_owner, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pc_load", bus.pc_load, 0);
        check("rst_cycles", bus.cycles, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // basic run followed immediately by a back-to-back run
        do_run(10'h040, 25, -1);
        do_run(10'h100, 10, -1);
        // timeout, done/timeout tie, abort at RUN cycle 7
        do_run(10'h155, 150, -1);
        do_run(10'h2AA, TMO, -1);
        do_run(10'h0F0, 0, 7);
        step();

        // arbitration A: grant held blocks start
        bus.host_req = 1'b1;
        step();
        check("arbA_gnt", bus.host_gnt, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("arbA_busy", bus.busy, 0);
        check("arbA_gnt_hold", bus.host_gnt, 1);
        step();
        check("arbA_busy2", bus.busy, 0);
        bus.host_req = 1'b0;
        step();
        check("arbA_gnt_drop", bus.host_gnt, 0);
        step();

        // arbitration B: simultaneous start and host_req, grant after DONE
        bus.host_req = 1'b1;
        do_run(10'h3C3, 5, -1);
        step();
        check("arbB_gnt_after", bus.host_gnt, 1);
        bus.host_req = 1'b0;
        step();
        step();
        check("arbB_gnt_drop", bus.host_gnt, 0);

        for (int i = 0; i < 10; i++) begin
            logic [D-1:0] a;
            int           n;
            int           ab;
            a  = D'($urandom);
            n  = $urandom_range(0, 115);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1;
            do_run(a, n, ab);
            repeat ($urandom_range(0, 3)) step();
        end

        // asynchronous reset in the middle of RUN
        bus.start_addr = 10'h1E1;
        bus.start      = 1'b1;
        addr_q.push_back(10'h1E1);
        step();
        bus.start = 1'b0;
        repeat (RST_CYC + 12) step();
        check("pre_async_busy", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_core_rst", bus.core_rst, 1);
        check("async_busy", bus.busy, 0);
        check("async_cycles", bus.cycles, 0);
        check("async_mem_owner", bus.mem_owner, 0);
        check("async_pc_load_val", bus.pc_load_val, 0);
        check("async_timeout", bus.timeout, 0);
        step();
        reset = 1'b0;
        step();
        do_run(10'h07E, 3, -1);
        repeat (3) step();

        check("exp_queue_empty", exp_q.size(), 0);
        check("addr_queue_empty", addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Run-level controller for the single-cycle core. It holds the core in reset between runs and releases it on a start request. It loads a program entry address into the PC through the PC's existing absolute-jump path, then counts execution cycles until the core's done flag or a timeout. It also arbitrates data-memory ownership between a host port (preload/readback) and the core.

Parameters:
D, 10, program counter width; matches the PC and instruction ROM.
CW, 16, cycle counter width.
RST_CYC, 2, number of cycles core_rst is held high after start; must be at least 1.
TIMEOUT_CYC, 16'hFFFF, RUN cycle count at which a run is aborted as timed out; must be at most 2^CW-1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  run request; sampled only in IDLE
start_addr  in  D  program entry address, captured when start is accepted
abort  in  1  cancels an in-progress run
core_done  in  1  core halt flag (all-ones machine code)
host_req  in  1  host requests data-memory ownership
host_gnt  out  1  host owns data memory
mem_owner  out  1  0 = host drives data memory, 1 = core drives it
core_rst  out  1  reset to the core's PC and register file
pc_load  out  1  one-cycle absolute-jump enable to the PC
pc_load_val  out  D  jump target presented to the PC
busy  out  1  high from start acceptance until the end of DONE
ack  out  1  one-cycle run-complete pulse
cycles  out  CW  RUN cycle count of the current or most recent run
timeout  out  1  most recent run ended by TIMEOUT_CYC

Behaviour:
- Reset (asynchronous, any state): state=IDLE, core_rst=1, mem_owner=0, and all other outputs 0 (host_gnt, pc_load, pc_load_val, busy, ack, cycles, timeout).
- Outputs are registered; every state transition takes effect at the clock edge.
- IDLE:
  - core_rst=1, mem_owner=0.
  - If host_gnt=0 and start=1: capture start_addr, clear cycles and timeout, set busy=1, go to RESET.
  - Else if host_req=1: host_gnt=1 at the next edge.
  - When start and host_req are high in the same cycle with host_gnt=0, start wins; host_req remains pending.
  - While host_gnt=1, start is ignored. host_gnt drops one cycle after host_req deasserts.
- RESET:
  - core_rst=1 for exactly RST_CYC cycles, tracked by an internal counter, then go to LOAD.
- LOAD (1 cycle):
  - core_rst=0, mem_owner=1, pc_load=1, pc_load_val=captured address; then go to RUN.
- RUN:
  - core_rst=0, mem_owner=1.
  - Each cycle with core_done=0: cycles+1.
  - core_done=1: go to DONE with cycles frozen; the done cycle is not counted.
  - cycles==TIMEOUT_CYC and core_done=0: set timeout=1, go to DONE.
  - If done and timeout coincide, done wins (timeout=0).
  - cycles never wraps.
- DONE (1 cycle):
  - ack=1, core_rst=1, mem_owner=0.
  - busy falls at the next edge; return to IDLE.
  - cycles and timeout hold until the next accepted start.
- abort=1 in RESET, LOAD or RUN: go to IDLE at the next edge with core_rst=1, busy=0, no ack, cycles held, timeout=0. abort is ignored in IDLE and DONE.
- host_req during a run is held pending and is granted in IDLE after DONE.
- pc_load_val holds the last captured address outside LOAD.

Decomposition:
- Package run_seq_pkg: state enum typedef (IDLE, RESET, LOAD, RUN, DONE) and owner constants OWNER_HOST=0, OWNER_CORE=1.
- One sub-module, run_cycle_ctr: saturating CW-bit counter with clear, enable and terminal-count compare. The FSM stays in run_sequencer.

Test Plan:
- Basic run:
  - Stimulus: start=1 with start_addr=10'h040 at cycle 0; core_done driven high 25 cycles after pc_load.
  - Required: core_rst high for 2 cycles; pc_load pulses once with val=10'h040; cycles=25; ack pulses once; timeout=0; busy falls the cycle after ack.
- Timeout:
  - Stimulus: TIMEOUT_CYC=100, core_done held low.
  - Required: timeout=1, cycles=100, ack pulses once, core_rst=1 and mem_owner=0 afterwards.
- Arbitration:
  - Stimulus A: host_req=1 in IDLE, then start=1 pulsed while host_gnt=1.
  - Required A: start ignored, busy stays 0; host_gnt drops 1 cycle after host_req falls.
  - Stimulus B: start and host_req rise in the same cycle.
  - Required B: run starts; host_gnt rises after DONE.
- Abort:
  - Stimulus: abort=1 at RUN cycle 7.
  - Required: IDLE next edge, no ack, cycles=7, core_rst=1, busy=0.
- Async reset mid-RUN:
  - Stimulus: reset asserted between clock edges.
  - Required: all outputs return to reset values immediately, without waiting for a clock edge.
- Done/timeout tie and back-to-back runs:
  - Stimulus 1: core_done rises in the same cycle cycles reaches TIMEOUT_CYC.
  - Required 1: timeout=0.
  - Stimulus 2: a second start with start_addr=10'h100 immediately after the first ack.
  - Required 2: cycles cleared to 0, pc_load_val=10'h100.
